// File: rtl/bcd_clock_pkg.sv
// Shared encodings, limits and helpers for the BCD time-of-day controller.
package bcd_clock_pkg;

  typedef enum logic [2:0] {
    StRun    = 3'd0,
    StSetHr  = 3'd1,
    StSetMin = 3'd2,
    StSetSec = 3'd3,
    StCommit = 3'd4
  } state_e;

  localparam logic [1:0] FIELD_RUN = 2'b00;
  localparam logic [1:0] FIELD_HR  = 2'b01;
  localparam logic [1:0] FIELD_MIN = 2'b10;
  localparam logic [1:0] FIELD_SEC = 2'b11;

  localparam logic [7:0] HR_MAX = 8'h23;
  localparam logic [7:0] MS_MAX = 8'h59;

  function automatic logic bcd_digits_ok(input logic [7:0] v);
    return (v[3:0] <= 4'd9) && (v[7:4] <= 4'd9);
  endfunction

  function automatic logic is_set_state(input state_e s);
    return (s == StSetHr) || (s == StSetMin) || (s == StSetSec);
  endfunction

  function automatic logic [1:0] field_of(input state_e s);
    logic [1:0] f;
    case (s)
      StSetHr:  f = FIELD_HR;
      StSetMin: f = FIELD_MIN;
      StSetSec: f = FIELD_SEC;
      default:  f = FIELD_RUN;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/bcd_field_inc.sv
// Packed-BCD +1 with wrap at MAX back to 00, plus a range/digit validity flag.
module bcd_field_inc
  import bcd_clock_pkg::*;
#(
  parameter logic [7:0] MAX = MS_MAX
) (
  input  logic [7:0] val,
  output logic [7:0] inc_val,
  output logic       valid
);

  logic [3:0] ms_plus;
  logic [3:0] ls_plus;

  always_comb begin
    ms_plus = val[7:4] + 4'd1;
    ls_plus = val[3:0] + 4'd1;
    // Packed BCD with legal digits orders the same as binary, so a plain compare works.
    valid   = bcd_digits_ok(val) && (val <= MAX);
    if (val >= MAX) begin
      inc_val = 8'h00;
    end else if (val[3:0] >= 4'd9) begin
      inc_val = {ms_plus, 4'd0};
    end else begin
      inc_val = {val[7:4], ls_plus};
    end
  end

endmodule

// File: rtl/bcd_clock_ctrl.sv
// Time-of-day controller: 1 Hz prescaler, two-button time-set FSM, edit registers
// and the one-cycle parallel load into the BCD counter.
module bcd_clock_ctrl
  import bcd_clock_pkg::*;
#(
  parameter int unsigned TICK_DIV = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic [7:0] cur_hr,
  input  logic [7:0] cur_min,
  input  logic [7:0] cur_sec,
  output logic       tick_en,
  output logic       load,
  output logic [7:0] load_hr,
  output logic [7:0] load_min,
  output logic [7:0] load_sec,
  output logic [1:0] set_field,
  output logic       blink
);

  localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TICK_DIV - 1);
  localparam logic [CntW-1:0] CntHalf = CntW'(TICK_DIV / 2);

  // Bit 0 = mode, bit 1 = inc.
  logic [1:0] sync1_q, sync2_q, prev_q;
  logic       mode_press, inc_press;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [7:0]      hr_q, hr_d, min_q, min_d, sec_q, sec_d;

  logic [7:0] hr_in, min_in, sec_in;
  logic [7:0] hr_inc, min_inc, sec_inc;
  logic       hr_ok, min_ok, sec_ok;

  assign mode_press = sync2_q[0] & ~prev_q[0];
  assign inc_press  = sync2_q[1] & ~prev_q[1];

  // In RUN the incrementers only range-check the live time for capture.
  assign hr_in  = (state_q == StRun) ? cur_hr  : hr_q;
  assign min_in = (state_q == StRun) ? cur_min : min_q;
  assign sec_in = (state_q == StRun) ? cur_sec : sec_q;

  bcd_field_inc #(.MAX(HR_MAX)) u_hr_inc (
    .val     (hr_in),
    .inc_val (hr_inc),
    .valid   (hr_ok)
  );

  bcd_field_inc #(.MAX(MS_MAX)) u_min_inc (
    .val     (min_in),
    .inc_val (min_inc),
    .valid   (min_ok)
  );

  bcd_field_inc #(.MAX(MS_MAX)) u_sec_inc (
    .val     (sec_in),
    .inc_val (sec_inc),
    .valid   (sec_ok)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = (cnt_q == CntLast) ? '0 : cnt_q + CntW'(1);
    hr_d    = hr_q;
    min_d   = min_q;
    sec_d   = sec_q;
    unique case (state_q)
      StRun: begin
        if (mode_press) begin
          state_d = StSetHr;
          cnt_d   = '0;
          hr_d    = hr_ok  ? cur_hr  : 8'h00;
          min_d   = min_ok ? cur_min : 8'h00;
          sec_d   = sec_ok ? cur_sec : 8'h00;
        end
      end
      StSetHr: begin
        if (mode_press)     state_d = StSetMin;
        else if (inc_press) hr_d    = hr_inc;
      end
      StSetMin: begin
        if (mode_press)     state_d = StSetSec;
        else if (inc_press) min_d   = min_inc;
      end
      StSetSec: begin
        if (mode_press)     state_d = StCommit;
        else if (inc_press) sec_d   = sec_inc;
      end
      StCommit: begin
        state_d = StRun;
        cnt_d   = '0;
      end
      default: begin
        state_d = StRun;
        cnt_d   = '0;
      end
    endcase
  end

  // Strobes are registered from next-state values so they line up with state_q/cnt_q.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q   <= 2'b00;
      sync2_q   <= 2'b00;
      prev_q    <= 2'b11;
      state_q   <= StRun;
      cnt_q     <= '0;
      hr_q      <= 8'h00;
      min_q     <= 8'h00;
      sec_q     <= 8'h00;
      tick_en   <= 1'b0;
      load      <= 1'b0;
      blink     <= 1'b0;
      set_field <= FIELD_RUN;
    end else begin
      sync1_q   <= {btn_inc, btn_mode};
      sync2_q   <= sync1_q;
      prev_q    <= sync2_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hr_q      <= hr_d;
      min_q     <= min_d;
      sec_q     <= sec_d;
      tick_en   <= (state_d == StRun) && (cnt_d == CntLast);
      load      <= (state_d == StCommit);
      blink     <= is_set_state(state_d) && (cnt_d >= CntHalf);
      set_field <= field_of(state_d);
    end
  end

  assign load_hr  = hr_q;
  assign load_min = min_q;
  assign load_sec = sec_q;

endmodule
